// File: rtl/sr_bank_pkg.sv
// Shared mode encoding for the S/R register bank.
// Mode selects how the forbidden S=R=1 pair is resolved on each enabled edge.
package sr_bank_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RDOM   = 2'd0;
  localparam mode_t MODE_SDOM   = 2'd1;
  localparam mode_t MODE_HOLD   = 2'd2;
  localparam mode_t MODE_TOGGLE = 2'd3;

endpackage

// File: rtl/sr_flop_bank_if.sv
// Bus between controller and S/R bank: sample controls in, registered state and error status out.
// No valid/ready handshake: every input is sampled at each rising edge where en=1 (clr_err regardless of en).
interface sr_flop_bank_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    import sr_bank_pkg::*;

    logic             en;
    mode_t            mode;
    logic [CH-1:0]    S;
    logic [CH-1:0]    R;
    logic             clr_err;
    logic [CH-1:0]    Q;
    logic [CH-1:0]    Qn;
    logic [CH-1:0]    q_chg;
    logic [CH-1:0]    conflict;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output en, mode, S, R, clr_err,
        input  Q, Qn, q_chg, conflict, conflict_cnt
    );

    modport slave (
        input  en, mode, S, R, clr_err,
        output Q, Qn, q_chg, conflict, conflict_cnt
    );

endinterface

// File: rtl/sr_cell.sv
// One S/R storage channel: next-state resolution, Q register and change pulse.
// Reset loads rst_val and suppresses q_chg even when that changes Q.
module sr_cell
    import sr_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  mode_t mode,
    input  logic  s,
    input  logic  r,
    input  logic  rst_val,
    output logic  q,
    output logic  q_chg
);

    logic q_next;

    always_comb begin
        q_next = q;
        case ({s, r})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_RDOM:   q_next = 1'b0;
                    MODE_SDOM:   q_next = 1'b1;
                    MODE_HOLD:   q_next = q;
                    MODE_TOGGLE: q_next = ~q;
                    default:     q_next = q;
                endcase
            end
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= rst_val;
            q_chg <= 1'b0;
        end else if (en) begin
            q     <= q_next;
            q_chg <= q_next ^ q;
        end else begin
            q_chg <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of CH clocked S/R channels with sticky per-channel conflict flags
// and a saturating count of enabled cycles that saw any S=R=1 pair.
module sr_flop_bank
    import sr_bank_pkg::*;
#(
    parameter int              CH      = 4,
    parameter logic [CH-1:0]   RESET_Q = {CH{1'b0}},
    parameter int              CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    sr_flop_bank_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CH-1:0]    q_reg;
    logic [CH-1:0]    chg_reg;
    logic [CH-1:0]    conflict_now;
    logic             any_conflict;
    logic [CH-1:0]    conflict_reg;
    logic [CNT_W-1:0] cnt_reg;

    for (genvar i = 0; i < CH; i++) begin : g_cell
        sr_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en),
            .mode    (bus.mode),
            .s       (bus.S[i]),
            .r       (bus.R[i]),
            .rst_val (RESET_Q[i]),
            .q       (q_reg[i]),
            .q_chg   (chg_reg[i])
        );
    end

    assign conflict_now = bus.S & bus.R;
    assign any_conflict = |conflict_now;

    // A conflict arriving with clr_err survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_reg <= '0;
            cnt_reg      <= '0;
        end else if (bus.clr_err) begin
            conflict_reg <= bus.en ? conflict_now : '0;
            cnt_reg      <= (bus.en && any_conflict) ? CNT_ONE : '0;
        end else if (bus.en) begin
            conflict_reg <= conflict_reg | conflict_now;
            if (any_conflict && (cnt_reg != CNT_MAX))
                cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    assign bus.Q            = q_reg;
    assign bus.Qn           = ~q_reg;
    assign bus.q_chg        = chg_reg;
    assign bus.conflict     = conflict_reg;
    assign bus.conflict_cnt = cnt_reg;

endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Clocked, parametrised successor to the single RS latch: CH independent S/R storage channels in one register bank, all sampled on a common clock.
- A runtime-selectable mode defines how the S=R=1 input pair is resolved: reset-dominant, set-dominant, hold, or toggle (JK behaviour).
- Per-channel sticky conflict flags, a saturating conflict counter and per-channel change pulses let downstream control logic and the bench observe forbidden-input activity.

Parameters:
- CH, 4, number of S/R channels (1..32).
- RESET_Q, {CH{1'b0}}, Q value loaded on reset, per channel.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  sample enable; when low, all state holds.
- mode  input  2  conflict resolution: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
- S  input  CH  per-channel set request.
- R  input  CH  per-channel reset request.
- clr_err  input  1  clears the conflict flags and the conflict counter.
- Q  output  CH  registered state.
- Qn  output  CH  ~Q, combinational from the Q register; never equal to Q.
- q_chg  output  CH  one-cycle pulse for each channel whose Q changed on the last edge.
- conflict  output  CH  sticky flag per channel; set when S=R=1 was sampled with en=1.
- conflict_cnt  output  CNT_W  saturating count of enabled cycles with at least one channel at S=R=1.

Behaviour:
- Reset: clk and rst_n are fixed as one clock with a synchronous, active-low reset. At a rising clk edge with rst_n=0: Q=RESET_Q, q_chg=0, conflict=0, conflict_cnt=0. Reset overrides en, clr_err and every other input.
- Latency: inputs are sampled at a rising edge where en=1. The new Q is visible immediately after that edge (one-cycle latency). No combinational path exists from S/R to Q.
- Per-channel next state when en=1:
  - S=0, R=0: hold.
  - S=1, R=0: Q=1.
  - S=0, R=1: Q=0.
  - S=1, R=1: mode 0 gives Q=0; mode 1 gives Q=1; mode 2 holds; mode 3 gives Q=~Q.
- Mode: sampled on the same edge as S/R. It can change on any cycle and takes effect on that edge. There is no latched mode state.
- en=0: Q holds, q_chg=0, conflict holds, conflict_cnt holds. S/R are ignored, including S=R=1.
- q_chg[i]: registered with Q; equals 1 for exactly the cycle after an edge on which Q[i] changed value. It is 0 after reset, even when reset changes Q.
- conflict[i]: set at any enabled edge where S[i]=R[i]=1, regardless of mode. Cleared only by reset or clr_err.
- conflict_cnt: increments by 1 per enabled edge on which any channel has S=R=1. It counts cycles, not channels. It saturates at 2^CNT_W-1 and never wraps.
- clr_err simultaneous with a new conflict: the new event wins. The flags then hold only this cycle's conflicting channels, and conflict_cnt=1.
- clr_err acts even when en=0, which gives flags=0 and cnt=0. clr_err does not affect Q.
- Reset mid-operation: pending toggles and conflicts are discarded. On the first enabled edge after rst_n rises, the inputs are evaluated against Q=RESET_Q.

Decomposition:
- Package sr_bank_pkg:
  - mode constants MODE_RDOM=2'd0, MODE_SDOM=2'd1, MODE_HOLD=2'd2, MODE_TOGGLE=2'd3.
  - a 2-bit mode typedef.
- Sub-module sr_cell: one channel's next-state function, Q register and q_chg register, with inputs clk, rst_n, en, mode, s, r, rst_val.
  - The top instantiates CH sr_cell instances with a generate loop.
  - The top owns the conflict flags and the counter.

Test Plan:
1. CH=4, RESET_Q=4'b1010, hold rst_n=0 for 2 edges -> Q=4'b1010, Qn=4'b0101, q_chg=0, conflict=0, cnt=0. Release and drive en=1, S=R=0 for 3 edges -> no change.
2. Channel 0 sequence (S,R) = (0,1), (0,0), (0,1), (1,0), (1,1) under mode 0 -> Q[0] after each edge is 0, 0, 0, 1, 0; q_chg[0] pulses after the 4th and 5th edges; conflict[0]=1; cnt=1.
3. Q=0, S=R=4'b1111 for 3 edges, repeated for each mode:
   - mode 1 -> Q=4'hF.
   - mode 2 -> Q=0.
   - mode 3 -> Q toggles 4'hF, 0, 4'hF and q_chg=4'hF each cycle.
   - cnt=3 in every case.
4. en=0 with S=R=4'hF for 5 edges -> Q, flags and cnt unchanged, q_chg=0.
5. CNT_W=3, 10 consecutive conflicting cycles -> cnt reaches 7 and stays 7. Then clr_err=1 alongside a conflict on channel 2 only -> conflict=4'b0100, cnt=1.
6. Mode 3 toggling in progress, then rst_n=0 for 1 edge -> Q=RESET_Q, flags and cnt=0. The next enabled S=R=1 edge toggles from RESET_Q.
